// File: rtl/lcd_pkg.sv
// Shared types, command constants and helpers for the HD44780 4-bit nibble driver.
// LCD_POWERON_INIT_EN adds the power-on initialisation states to the state type.
package lcd_pkg;

  typedef enum logic [3:0] {
`ifdef LCD_POWERON_INIT_EN
    INIT_WAIT,
    INIT_NIB,
`endif
    IDLE,
    SETUP_HI,
    PULSE_HI,
    GAP,
    SETUP_LO,
    PULSE_LO,
    EXEC_WAIT
  } lcd_state_e;

  localparam logic [7:0] LCD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_HOME    = 8'h02;
  localparam logic [7:0] LCD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_DISP_ON = 8'h0C;
  localparam logic [7:0] LCD_FUNC_4B = 8'h28;

  // Wake-up nibble 0x3 three times, then 0x2 switches the controller to 4-bit mode.
  localparam logic [3:0]  INIT_NIB_WAKE      = 4'h3;
  localparam logic [3:0]  INIT_NIB_4BIT      = 4'h2;
  localparam logic [2:0]  INIT_STEPS         = 3'd4;
  localparam int unsigned INIT_WAIT1_CYC_DEF = 205000;
  localparam int unsigned INIT_WAIT2_CYC_DEF = 5000;

  function automatic logic [3:0] init_nibble(input logic [2:0] step);
    return (step == 3'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
  endfunction

  // Clear (0x00/0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data[7:1] == 7'b0000000) || (data[7:1] == 7'b0000001));
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter that parks at zero; zero_o marks the final cycle of a timed state.
module lcd_wait_timer #(
  parameter int unsigned    W         = 8,
  parameter logic [W-1:0]   RST_VALUE = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= RST_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit write engine: each accepted byte goes out as two timed nibble strobes.
// Define LCD_POWERON_INIT_EN to run the 3,3,3,2 power-on sequence before accepting bytes.
module lcd_nibble_driver
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned E_HIGH_CYC     = 12,
  parameter int unsigned GAP_CYC        = 50,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000,
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned INIT_WAIT1_CYC = INIT_WAIT1_CYC_DEF,
  parameter int unsigned INIT_WAIT2_CYC = INIT_WAIT2_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_4,
  output logic       lcd_5,
  output logic       lcd_6,
  output logic       lcd_7
);

  localparam int unsigned MAX_CYC =
    max2(max2(max2(SETUP_CYC, E_HIGH_CYC), max2(GAP_CYC, CMD_WAIT_CYC)),
         max2(max2(CLEAR_WAIT_CYC, POWERUP_CYC), max2(INIT_WAIT1_CYC, INIT_WAIT2_CYC)));
  localparam int unsigned CW = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EHIGH = CW'(E_HIGH_CYC - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_CLEAR = CW'(CLEAR_WAIT_CYC - 1);

`ifdef LCD_POWERON_INIT_EN
  localparam lcd_state_e    RESET_STATE = INIT_WAIT;
  localparam logic [CW-1:0] RESET_COUNT = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] LD_W1       = CW'(INIT_WAIT1_CYC - 1);
  localparam logic [CW-1:0] LD_W2       = CW'(INIT_WAIT2_CYC - 1);
`else
  localparam lcd_state_e    RESET_STATE = IDLE;
  localparam logic [CW-1:0] RESET_COUNT = '0;
`endif

  lcd_state_e    state_q, state_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          lcd_e_q, lcd_e_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic [3:0]    nib_q, nib_d;
  logic          req_ready_q, req_ready_d;
  logic          init_done_q, init_done_d;

  logic          accept_s;
  logic          t_load_s;
  logic [CW-1:0] t_load_val_s;
  logic          t_zero_s;
  logic [CW-1:0] exec_load_s;
  lcd_state_e    post_state_s;
  logic [CW-1:0] post_load_s;

  lcd_wait_timer #(
    .W         (CW),
    .RST_VALUE (RESET_COUNT)
  ) u_timer (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (t_load_s),
    .load_value_i (t_load_val_s),
    .zero_o       (t_zero_s)
  );

  assign accept_s    = (state_q == IDLE) && req_valid && req_ready_q;
  assign exec_load_s = needs_long_wait(rs_q, data_q) ? LD_CLEAR : LD_CMD;

`ifdef LCD_POWERON_INIT_EN
  logic [2:0]    step_q, step_d;
  logic [CW-1:0] init_load_s;

  // Steps count nibbles already issued, so step 1 follows the first 0x3.
  always_comb begin
    case (step_q)
      3'd1:    init_load_s = LD_W1;
      3'd2:    init_load_s = LD_W2;
      default: init_load_s = LD_CMD;
    endcase
  end

  assign post_state_s = init_done_q ? EXEC_WAIT : INIT_WAIT;
  assign post_load_s  = init_done_q ? exec_load_s : init_load_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= 3'd0;
    end else begin
      step_q <= step_d;
    end
  end
`else
  assign post_state_s = EXEC_WAIT;
  assign post_load_s  = exec_load_s;
`endif

  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    data_d       = data_q;
    t_load_s     = 1'b0;
    t_load_val_s = '0;
`ifdef LCD_POWERON_INIT_EN
    step_d       = step_q;
`endif
    case (state_q)
`ifdef LCD_POWERON_INIT_EN
      INIT_WAIT: begin
        if (t_zero_s && (step_q == INIT_STEPS)) begin
          state_d = IDLE;
        end else if (t_zero_s) begin
          // Init nibbles reuse the low-nibble setup/pulse path with rs forced to 0.
          state_d      = INIT_NIB;
          rs_d         = 1'b0;
          data_d       = {4'h0, init_nibble(step_q)};
          step_d       = step_q + 3'd1;
          t_load_s     = 1'b1;
          t_load_val_s = LD_SETUP;
        end else begin
          state_d = INIT_WAIT;
        end
      end
      INIT_NIB: begin
        if (t_zero_s) begin
          state_d = PULSE_LO; t_load_s = 1'b1; t_load_val_s = LD_EHIGH;
        end else begin
          state_d = INIT_NIB;
        end
      end
`endif
      IDLE: begin
        if (accept_s) begin
          state_d      = SETUP_HI;
          rs_d         = req_rs;
          data_d       = req_data;
          t_load_s     = 1'b1;
          t_load_val_s = LD_SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP_HI: begin
        if (t_zero_s) begin
          state_d = PULSE_HI; t_load_s = 1'b1; t_load_val_s = LD_EHIGH;
        end else begin
          state_d = SETUP_HI;
        end
      end
      PULSE_HI: begin
        if (t_zero_s) begin
          state_d = GAP; t_load_s = 1'b1; t_load_val_s = LD_GAP;
        end else begin
          state_d = PULSE_HI;
        end
      end
      GAP: begin
        if (t_zero_s) begin
          state_d = SETUP_LO; t_load_s = 1'b1; t_load_val_s = LD_SETUP;
        end else begin
          state_d = GAP;
        end
      end
      SETUP_LO: begin
        if (t_zero_s) begin
          state_d = PULSE_LO; t_load_s = 1'b1; t_load_val_s = LD_EHIGH;
        end else begin
          state_d = SETUP_LO;
        end
      end
      PULSE_LO: begin
        if (t_zero_s) begin
          state_d = post_state_s; t_load_s = 1'b1; t_load_val_s = post_load_s;
        end else begin
          state_d = PULSE_LO;
        end
      end
      EXEC_WAIT: begin
        if (t_zero_s) begin
          state_d = IDLE;
        end else begin
          state_d = EXEC_WAIT;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Bus outputs follow the registered state, so they lag the state by one cycle.
  always_comb begin
    lcd_e_d     = 1'b0;
    lcd_rs_d    = lcd_rs_q;
    nib_d       = nib_q;
    req_ready_d = (state_q == IDLE) && !accept_s;
`ifdef LCD_POWERON_INIT_EN
    init_done_d = init_done_q || (state_q == IDLE);
`else
    init_done_d = 1'b1;
`endif
    case (state_q)
      SETUP_HI, GAP: begin
        lcd_rs_d = rs_q; nib_d = data_q[7:4];
      end
      PULSE_HI: begin
        lcd_e_d = 1'b1; lcd_rs_d = rs_q; nib_d = data_q[7:4];
      end
      SETUP_LO, EXEC_WAIT: begin
        lcd_rs_d = rs_q; nib_d = data_q[3:0];
      end
`ifdef LCD_POWERON_INIT_EN
      INIT_NIB: begin
        lcd_rs_d = rs_q; nib_d = data_q[3:0];
      end
`endif
      PULSE_LO: begin
        lcd_e_d = 1'b1; lcd_rs_d = rs_q; nib_d = data_q[3:0];
      end
      default: begin
        lcd_e_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      nib_q       <= 4'h0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      nib_q       <= nib_d;
      req_ready_q <= req_ready_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign init_done = init_done_q;
  assign lcd_e     = lcd_e_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_4     = nib_q[0];
  assign lcd_5     = nib_q[1];
  assign lcd_6     = nib_q[2];
  assign lcd_7     = nib_q[3];

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Directed/randomised bench for lcd_nibble_driver; expected waveforms come from a timeline model.
// Honours LCD_POWERON_INIT_EN when the design is built with the init sequence.
module tb_lcd_nibble_driver;

  localparam int unsigned S   = 2;
  localparam int unsigned E   = 4;
  localparam int unsigned G   = 3;
  localparam int unsigned CMD = 10;
  localparam int unsigned CLR = 40;
  localparam int unsigned PWR = 20;
  localparam int unsigned IW  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, lcd_e, lcd_rs, lcd_rw;
  logic       lcd_4, lcd_5, lcd_6, lcd_7;
  logic [3:0] nib;

  int n_checks = 0;
  int n_fail   = 0;

  assign nib = {lcd_7, lcd_6, lcd_5, lcd_4};

  always #5 clk = ~clk;

  lcd_nibble_driver #(
    .SETUP_CYC      (S),
    .E_HIGH_CYC     (E),
    .GAP_CYC        (G),
    .CMD_WAIT_CYC   (CMD),
    .CLEAR_WAIT_CYC (CLR),
    .POWERUP_CYC    (PWR),
    .INIT_WAIT1_CYC (IW),
    .INIT_WAIT2_CYC (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .init_done (init_done),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_4     (lcd_4),
    .lcd_5     (lcd_5),
    .lcd_6     (lcd_6),
    .lcd_7     (lcd_7)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lcd_rw must read 0 on every cycle of every test.
  always @(negedge clk) check("lcd_rw", 32'(lcd_rw), 32'd0);

  task automatic check_reset_values(input string tag);
    check({tag, "_e"},     32'(lcd_e),     32'd0);
    check({tag, "_rs"},    32'(lcd_rs),    32'd0);
    check({tag, "_nib"},   32'(nib),       32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_done"},  32'(init_done), 32'd0);
  endtask

  // Called at the negedge right after rst was dropped.
  task automatic release_reset();
`ifdef LCD_POWERON_INIT_EN
    int c = 0;
    int rises = 0;
    int last_fall = 0;
    logic prev_e = 1'b0;
    int wait_tab [4] = '{IW, IW, CMD, CMD};
    logic [3:0] nib_tab [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    req_valid = 1'b1;
    req_rs    = 1'($urandom_range(0, 1));
    req_data  = 8'($urandom);
    while (c < 500) begin
      @(negedge clk);
      c++;
      if (lcd_e && !prev_e) begin
        if (rises < 4) begin
          check($sformatf("init_nib%0d", rises), 32'(nib), 32'(nib_tab[rises]));
          check($sformatf("init_rs%0d", rises), 32'(lcd_rs), 32'd0);
          if (rises == 0) check("init_rise0_time", c, PWR + 1 + S);
          else check($sformatf("init_rise%0d_time", rises), c, last_fall + wait_tab[rises-1] + S);
        end else begin
          check("init_extra_rise", rises + 1, 32'd4);
        end
        rises++;
      end
      if (!lcd_e && prev_e) last_fall = c;
      prev_e = lcd_e;
      if (req_ready === 1'b1 || init_done === 1'b1) break;
    end
    req_valid = 1'b0;
    check("init_ready",      32'(req_ready), 32'd1);
    check("init_done",       32'(init_done), 32'd1);
    check("init_rise_count", rises, 32'd4);
    check("init_end_time",   c, last_fall + CMD);
`else
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);
    check("done_after_rst",  32'(init_done), 32'd1);
`endif
  endtask

  // One byte: wait for ready, present it, then compare every cycle with the timeline.
  task automatic xfer(input logic rs, input logic [7:0] data, input logic hold,
                      input logic nrs, input logic [7:0] ndata);
    int budget = 200;
    int w;
    int t_end;
    logic exp_e;
    logic [3:0] exp_nib;
    while (req_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = data;
    @(posedge clk);
    w     = (rs == 1'b0 && data < 8'd4) ? CLR : CMD;
    t_end = 2*S + 2*E + G + w + 1;
    for (int d = 0; d <= t_end; d++) begin
      @(negedge clk);
      if (d == 0) begin
        req_valid = hold;
        req_rs    = nrs;
        req_data  = ndata;
        check("ready_drop", 32'(req_ready), 32'd0);
      end else begin
        exp_e   = ((d >= 1+S) && (d < 1+S+E)) || ((d >= 1+2*S+E+G) && (d < 1+2*S+2*E+G));
        exp_nib = (d < 1+S+E+G) ? data[7:4] : data[3:0];
        check($sformatf("e_%02h@%0d", data, d),     32'(lcd_e),     32'(exp_e));
        check($sformatf("nib_%02h@%0d", data, d),   32'(nib),       32'(exp_nib));
        check($sformatf("rs_%02h@%0d", data, d),    32'(lcd_rs),    32'(rs));
        check($sformatf("ready_%02h@%0d", data, d), 32'(req_ready), (d == t_end) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q [3];
    logic       rs_v;
    logic [7:0] d_v;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    release_reset();

    xfer(1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    xfer(1'b0, 8'h01, 1'b0, 1'b0, 8'h00);
    xfer(1'b0, 8'h28, 1'b0, 1'b0, 8'h00);
    xfer(1'b0, 8'h03, 1'b0, 1'b0, 8'h00);
    xfer(1'b0, 8'h04, 1'b0, 1'b0, 8'h00);
    xfer(1'b1, 8'h01, 1'b0, 1'b0, 8'h00);
    xfer(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // req_valid stays high across three queued bytes.
    for (int i = 0; i < 3; i++) q[i] = 8'($urandom);
    xfer(1'b1, q[0], 1'b1, 1'b1, q[1]);
    xfer(1'b1, q[1], 1'b1, 1'b1, q[2]);
    xfer(1'b1, q[2], 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_e",     32'(lcd_e),     32'd0);
      check("idle_ready", 32'(req_ready), 32'd1);
    end

    // Random bytes with garbage held on the request lines while busy.
    for (int i = 0; i < 8; i++) begin
      rs_v = 1'($urandom_range(0, 1));
      d_v  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      xfer(rs_v, d_v, (i != 7), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Reset while lcd_e is high.
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (1 + S) @(negedge clk);
    check("pulse_before_rst", 32'(lcd_e), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("mid_rst");
    rst = 1'b0;
    release_reset();
    xfer(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_driver.md
# lcd_nibble_driver

Byte-to-nibble write engine for the HD44780-compatible character LCD on the board's 4-bit bus (lcd_e, lcd_rs, lcd_rw, lcd_4..lcd_7). Sits directly downstream of the Lab3 top-level control logic. It accepts one command or data byte per valid/ready handshake and emits the high nibble then the low nibble with HD44780 setup, enable-pulse and execution timing. It optionally runs the power-on 4-bit initialisation sequence. Write-only: lcd_rw is tied low and the busy flag is never read.

## Interface
- SETUP_CYC, 2: cycles lcd_rs/data are stable before lcd_e rises (≥40 ns at 50 MHz).
- E_HIGH_CYC, 12: lcd_e high width in cycles (≥230 ns).
- GAP_CYC, 50: cycles between the high-nibble and low-nibble pulses, measured from lcd_e fall (≥1 µs).
- CMD_WAIT_CYC, 2000: post-byte execution wait (≥40 µs).
- CLEAR_WAIT_CYC, 82000: post-byte wait for clear/home commands (≥1.64 ms).
- POWERUP_CYC, 750000: initial wait before the first init nibble (15 ms). Used only with the init feature.
- clk  in  1  system clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a byte.
- req_rs  in  1  0 = command, 1 = data.
- req_data  in  8  byte to write.
- init_done  out  1  power-on sequence complete (sticky).
- lcd_e, lcd_rs, lcd_rw  out  1 each  LCD strobe, register select, read/write (lcd_rw constant 0).
- lcd_4..lcd_7  out  1 each  LCD data nibble; lcd_7 is the MSB.

## Operation
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_4..7=0, req_ready=0, init_done=0. All outputs are registered.
- States: INIT_WAIT, INIT_NIB, IDLE, SETUP_HI, PULSE_HI, GAP, SETUP_LO, PULSE_LO, EXEC_WAIT.
- IDLE: req_ready=1. A transfer is accepted on the edge where req_valid && req_ready. The driver latches req_rs and req_data, drops req_ready, and moves to SETUP_HI.
- SETUP_HI: drives lcd_rs=req_rs and lcd_7..4=data[7:4] with lcd_e=0 for SETUP_CYC cycles.
- PULSE_HI: lcd_e=1 for E_HIGH_CYC cycles.
- GAP: lcd_e=0 for GAP_CYC cycles. The high nibble is held on the bus throughout GAP.
- SETUP_LO / PULSE_LO: same as SETUP_HI / PULSE_HI, with data[3:0] on the bus.
- EXEC_WAIT: lcd_e=0 and the low nibble stays on the bus.
  - Wait length is CLEAR_WAIT_CYC if rs=0 and data[7:1]==7'b0000000 (0x01 clear) or data[7:1]==7'b0000001 (0x02/0x03 home).
  - Otherwise the wait length is CMD_WAIT_CYC.
  - The state then returns to IDLE.
- req_valid outside IDLE is ignored. There is no queueing, and request inputs are not sampled until req_ready=1.
- Zero counts are illegal; every parameter must be ≥1.
- The timer is a down-counter sized $clog2 of the largest parameter plus 1. It loads count-1 on state entry, and the state exits on the cycle the counter reaches 0.

## Timing
- Accept at edge k. The bus changes at edge k+1 (first SETUP_HI cycle).
- lcd_e rises at edge k+1+SETUP_CYC and falls E_HIGH_CYC cycles later.
- The low nibble appears GAP_CYC cycles after the first lcd_e fall.
- req_ready reasserts after 2·SETUP_CYC + 2·E_HIGH_CYC + GAP_CYC + WAIT + 1 cycles from accept.
- Back-to-back requests: the next accept can occur on the first cycle req_ready=1.
- Reset mid-transfer: at the next edge with rst high, all outputs take their reset values (lcd_e drops immediately). The partial byte is discarded. With the init feature enabled, the init sequence restarts.
- Without the init feature, req_ready rises on the first edge with rst low.

## Configuration
- LCD_POWERON_INIT_EN defined:
  - After reset the driver runs INIT_WAIT (POWERUP_CYC).
  - It then sends single nibbles with rs=0: 0x3 (wait 205000), 0x3 (wait 5000), 0x3 (wait CMD_WAIT_CYC), 0x2 (wait CMD_WAIT_CYC).
  - Each init nibble uses the SETUP_CYC/E_HIGH_CYC pulse timing.
  - After the last wait, init_done=1 and the driver enters IDLE.
- LCD_POWERON_INIT_EN undefined: the INIT_* states are absent, init_done=1 from the first edge with rst low, and the reset state is IDLE.

## Structure
- Package lcd_pkg holds:
  - the state enum;
  - command constants LCD_CLEAR=8'h01, LCD_HOME=8'h02, LCD_ENTRY=8'h06, LCD_DISP_ON=8'h0C, LCD_FUNC_4B=8'h28;
  - init nibble/wait constants.
- One sub-module, lcd_wait_timer: loadable down-counter with load, load_value, and a zero flag. The FSM instantiates one copy.

## Test plan
Benches run with small parameters: SETUP=2, E_HIGH=4, GAP=3, CMD_WAIT=10, CLEAR_WAIT=40, POWERUP=20, init waits scaled to 8.
- Data write (rs=1, data=0x41) -> lcd_rs=1 throughout; nibble 0x4 then 0x1; two 4-cycle lcd_e pulses separated by 3 cycles; req_ready back after 2·2+2·4+3+10+1 = 26 cycles.
- Command 0x01 -> EXEC_WAIT lasts 40 cycles. Command 0x28 -> EXEC_WAIT lasts 10 cycles.
- req_valid held high with 3 queued bytes -> exactly 3 transfers; no byte is skipped or sampled outside IDLE.
- rst asserted during PULSE_HI -> next edge: lcd_e=0 and all outputs at reset values; the next request after recovery transfers cleanly.
- With LCD_POWERON_INIT_EN: nibbles 3,3,3,2 appear with rs=0 and the programmed gaps. req_ready and init_done stay 0 until the sequence ends, and req_valid during init is ignored.
- Without the macro: req_ready=1 and init_done=1 one edge after rst deasserts; lcd_rw=0 in every cycle of every test.
